// File: rtl/plpbot_uart_pkg.sv
// Shared definitions for the UART-driven bus master: protocol byte codes
// and the state encodings of the packet parser and the serial receiver.
package plpbot_uart_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } parser_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

endpackage

// File: rtl/plpbot_uart_rx.sv
// 8N1 serial receiver with 16x oversampling. Emits a one-cycle strobe with
// the received byte, or a one-cycle framing-error strobe when the stop bit
// samples low.
//
// state   | meaning
// R_IDLE  | line idle, waiting for a synchronized falling edge
// R_START | counting to mid-start, re-checking the line is still low
// R_DATA  | sampling 8 data bits LSB first, one per 16 ticks
// R_STOP  | sampling the stop bit, then strobe byte or framing error
module plpbot_uart_rx
  import plpbot_uart_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [7:0] rx_data
);

  localparam int DIV16 = CLK_HZ / (16 * BAUD);
  localparam int PW    = (DIV16 > 1) ? $clog2(DIV16) : 1;

  logic          rx_s1, rx_s2, rx_d;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  rx_state_t     state;

  assign tick = (pre_cnt == PW'(DIV16 - 1));

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Oversampling prescaler and frame FSM; prescaler restarts at each start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= R_IDLE;
      pre_cnt  <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (state == R_IDLE || tick) pre_cnt <= '0;
      else                         pre_cnt <= pre_cnt + 1'b1;
      case (state)
        R_IDLE: begin
          if (rx_d && !rx_s2) begin
            state    <= R_START;
            tick_cnt <= '0;
          end
        end
        R_START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_s2 ? R_IDLE : R_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        R_DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 4'd15) begin
              shreg   <= {rx_s2, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= R_STOP;
            end
          end
        end
        R_STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 4'd15) begin
              state <= R_IDLE;
              if (rx_s2) begin
                rx_valid <= 1'b1;
                rx_data  <= shreg;
              end else begin
                rx_ferr <= 1'b1;
              end
            end
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/plpbot_uart_bus_master.sv
// UART host bridge: parses 'W' addr[4] data[4] and 'R' addr[4] packets,
// performs one single-cycle bus access, and answers with ACK, the four read
// bytes, or NAK for an unknown command byte. Half-duplex: bytes arriving
// while an access or response is in progress are ignored.
// Optional build macro PLPBOT_UART_BUS_MASTER_TIMEOUT_EN adds an inter-byte
// timeout that abandons a partial packet in ADDR/DATA.
//
// state   | meaning
// ST_IDLE | waiting for a command byte
// ST_ADDR | collecting 4 address bytes, big-endian
// ST_DATA | collecting 4 write-data bytes, big-endian
// ST_BUS  | the single de=1 cycle; read data captured at its end
// ST_RESP | transmitting ACK / read bytes / NAK, then back to idle
module plpbot_uart_bus_master
  import plpbot_uart_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        txd,
  output logic        de,
  output logic        drw,
  output logic [31:0] daddr,
  output logic [31:0] dout,
  input  logic [31:0] din,
  output logic        busy
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int BW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_data;
  parser_state_t state;
  logic          cmd_w;
  logic [1:0]    byte_cnt;
  logic [31:0]   addr_reg, data_reg, resp_buf;
  logic [2:0]    resp_left;
  logic          tx_active;
  logic [8:0]    tx_shift;
  logic [3:0]    tx_bits;
  logic [BW-1:0] tx_baud;
  logic          frame_done, tx_load;

`ifdef PLPBOT_UART_BUS_MASTER_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BITS * BIT_DIV;
  logic [31:0] to_cnt;
`endif

  plpbot_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_data  (rx_data)
  );

  assign daddr = addr_reg;
  assign dout  = data_reg;
  assign busy  = (state != ST_IDLE);

  // Stop bit of the current frame is ending; the next byte, if any, starts
  // on the same edge so frames go out back-to-back.
  assign frame_done = tx_active && (tx_baud == BW'(BIT_DIV - 1)) && (tx_bits == 4'd0);
  assign tx_load    = (state == ST_RESP) && (resp_left != 3'd0) && (!tx_active || frame_done);

  // Packet parser, bus strobe and serial transmitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_w     <= 1'b0;
      byte_cnt  <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      de        <= 1'b0;
      drw       <= 1'b0;
      txd       <= 1'b1;
      tx_active <= 1'b0;
      tx_shift  <= '0;
      tx_bits   <= '0;
      tx_baud   <= '0;
`ifdef PLPBOT_UART_BUS_MASTER_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      de <= 1'b0;

      if (tx_load) begin
        txd       <= 1'b0;
        tx_shift  <= {1'b1, resp_buf[31:24]};
        tx_bits   <= 4'd9;
        tx_baud   <= '0;
        tx_active <= 1'b1;
        resp_buf  <= {resp_buf[23:0], 8'h00};
        resp_left <= resp_left - 1'b1;
      end else if (tx_active) begin
        if (tx_baud == BW'(BIT_DIV - 1)) begin
          tx_baud <= '0;
          if (tx_bits == 4'd0) begin
            tx_active <= 1'b0;
            txd       <= 1'b1;
          end else begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[8:1]};
            tx_bits  <= tx_bits - 1'b1;
          end
        end else begin
          tx_baud <= tx_baud + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              cmd_w    <= (rx_data == CMD_WRITE);
              byte_cnt <= '0;
              state    <= ST_ADDR;
            end else begin
              resp_buf  <= {RSP_NAK, 24'h0};
              resp_left <= 3'd1;
              state     <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (rx_ferr) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            addr_reg <= {addr_reg[23:0], rx_data};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              if (cmd_w) begin
                state <= ST_DATA;
              end else begin
                state <= ST_BUS;
                de    <= 1'b1;
                drw   <= 1'b0;
              end
            end
          end
        end
        ST_DATA: begin
          if (rx_ferr) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            data_reg <= {data_reg[23:0], rx_data};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              state <= ST_BUS;
              de    <= 1'b1;
              drw   <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (cmd_w) begin
            resp_buf  <= {RSP_ACK, 24'h0};
            resp_left <= 3'd1;
          end else begin
            resp_buf  <= din;
            resp_left <= 3'd4;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (frame_done && resp_left == 3'd0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

`ifdef PLPBOT_UART_BUS_MASTER_TIMEOUT_EN
      // Bit-period silence measured from the previous completed byte.
      if ((state == ST_ADDR || state == ST_DATA) && !rx_valid) begin
        if (to_cnt == 32'(TO_CYC - 1)) begin
          to_cnt <= '0;
          state  <= ST_IDLE;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_plpbot_uart_bus_master.sv
// Scoreboard bench: stimulus pushes expected bus accesses and response
// bytes; independent monitors pop and compare as the DUT produces them.
module tb_plpbot_uart_bus_master;

  localparam int CLK_HZ = 3200000;
  localparam int BAUD   = 100000;
  localparam int BITC   = CLK_HZ / BAUD;  // 32 clocks per bit

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        txd, de, drw, busy;
  logic [31:0] daddr, dout;
  logic [31:0] din = 32'h0;

  typedef struct {
    logic        drw;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  plpbot_uart_bus_master #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(40)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .txd   (txd),
    .de    (de),
    .drw   (drw),
    .daddr (daddr),
    .dout  (dout),
    .din   (din),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BITC) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    bus_q.push_back('{drw: 1'b1, addr: a, data: d});
    tx_q.push_back(8'h06);
    send_byte(8'h57, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
  endtask

  task automatic send_read(input logic [31:0] a, input logic [31:0] rd);
    din = rd;
    bus_q.push_back('{drw: 1'b0, addr: a, data: 32'h0});
    for (int i = 3; i >= 0; i--) tx_q.push_back(rd[i*8 +: 8]);
    send_byte(8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (tx_q.size() == 0 && bus_q.size() == 0 && !busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: still pending tx=%0d bus=%0d busy=%0b expected all drained and idle",
               name, tx_q.size(), bus_q.size(), busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txd"}, {31'h0, txd}, 32'h1);
    check({tag, "_de"}, {31'h0, de}, 32'h0);
    check({tag, "_drw"}, {31'h0, drw}, 32'h0);
    check({tag, "_daddr"}, daddr, 32'h0);
    check({tag, "_dout"}, dout, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // Bus monitor: every de cycle must match the next expected access.
  initial begin
    bus_exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (de) begin
        checks++;
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: de=1 drw=%0b daddr=%h expected no access", drw, daddr);
        end else begin
          e = bus_q.pop_front();
          check("bus_drw", {31'h0, drw}, {31'h0, e.drw});
          check("bus_daddr", daddr, e.addr);
          if (e.drw) check("bus_dout", dout, e.data);
        end
      end
    end
  end

  // Serial monitor: decode txd frames at mid-bit and compare each byte.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (txd == 1'b0) begin
        repeat (BITC/2 - 1) @(negedge clk);
        check("tx_start", {31'h0, txd}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (BITC) @(negedge clk);
          b[i] = txd;
        end
        repeat (BITC) @(negedge clk);
        check("tx_stop", {31'h0, txd}, 32'h1);
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got byte %h expected no response", b);
        end else begin
          e = tx_q.pop_front();
          if (b !== e) begin
            errors++;
            $display("FAIL tx_byte: got %h expected %h", b, e);
          end
        end
      end
    end
  end

  initial begin
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    mon_en = 1'b1;

    // Write 0x41 to 0x0000000C, expect ACK.
    send_write(32'h0000000C, 32'h00000041);
    wait_idle("write_basic", 3000);

    // Read 0x00000004 with din=3, expect 00 00 00 03.
    send_read(32'h00000004, 32'h00000003);
    wait_idle("read_basic", 3000);

    // Unknown command byte: NAK, busy during response, idle afterwards.
    tx_q.push_back(8'h15);
    send_byte(8'h3F, 1'b1);
    check("nak_busy", {31'h0, busy}, 32'h1);
    wait_idle("nak", 1500);

    // Framing error mid-address: silent drop, then a clean write.
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h41, 1'b0);
    repeat (4 * BITC) @(negedge clk);
    check("ferr_idle", {31'h0, busy}, 32'h0);
    send_write(32'h12345678, 32'hDEADBEEF);
    wait_idle("after_ferr_write", 3000);

    // Reset after 6 bytes of a write: discarded, outputs back to reset values.
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h00, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");

    // Fresh read after reset; a byte sent during the response is ignored.
    send_read(32'h80000001, 32'hA5A55A5A);
    send_byte(8'h3F, 1'b1);
    wait_idle("read_after_rst", 3000);

`ifdef PLPBOT_UART_BUS_MASTER_TIMEOUT_EN
    // Partial read abandoned after 41 silent bit periods, next write succeeds.
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (41 * BITC) @(negedge clk);
    check("timeout_idle", {31'h0, busy}, 32'h0);
    send_write(32'h00000020, 32'h00000099);
    wait_idle("timeout_then_write", 3000);
`endif

    repeat (2 * BITC) @(negedge clk);
    check("bus_q_empty", bus_q.size(), 32'h0);
    check("tx_q_empty", tx_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
